// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, timing-width helpers and the parity function.
// Pure declarations, no logic of its own.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  // Widest word the parity helper accepts; callers zero-extend into it.
  localparam int PAR_W = 16;

  function automatic int half_of(input int clks_per_bit);
    return clks_per_bit / 2;
  endfunction

  function automatic int cnt_w_of(input int clks_per_bit);
    return $clog2(clks_per_bit);
  endfunction

  function automatic int idx_w_of(input int data_bits);
    return $clog2(data_bits + 1);
  endfunction

  function automatic logic parity_of(input logic [PAR_W-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous bit; 2-cycle latency, no backpressure.
// Reset loads RST_VAL into both stages so an idle-high line never looks like an edge.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Oversampled UART receiver with configurable width, parity and stop bits; rx_valid at mid last stop bit.
// No backpressure: the consumer must take data_out and the error flags on the rx_valid pulse.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter bit PARITY_EN    = 1'b1,
  parameter bit PARITY_ODD   = 1'b0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int HALF  = half_of(CLKS_PER_BIT);
  localparam int CNT_W = cnt_w_of(CLKS_PER_BIT);
  localparam int IDX_W = idx_w_of(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = (STOP_BITS == 2);

  rx_state_t            state;
  logic                 rx_s;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 ferr_pend;
  logic                 par_exp;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  assign par_exp = parity_of(PAR_W'(shreg), PARITY_ODD);
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      idx        <= '0;
      stop_cnt   <= 1'b0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      ferr_pend  <= 1'b0;
      data_out   <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= ST_START;
        end
        ST_START: begin
          if (cnt == CNT_HALF) begin
            cnt       <= '0;
            idx       <= '0;
            stop_cnt  <= 1'b0;
            ferr_pend <= 1'b0;
            // A line that is high again at mid-start was only a glitch.
            state     <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            idx   <= idx + 1'b1;
            if (idx == IDX_LAST) state <= PARITY_EN ? ST_PARITY : ST_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            par_bit <= rx_s;
            state   <= ST_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            // Leaving at mid-stop lets a following start edge be caught without an idle gap.
            if (stop_cnt == STOP_LAST) begin
              state      <= ST_IDLE;
              data_out   <= shreg;
              parity_err <= PARITY_EN && (par_bit != par_exp);
              frame_err  <= ferr_pend | ~rx_s;
              rx_valid   <= 1'b1;
            end else begin
              stop_cnt  <= 1'b1;
              ferr_pend <= ferr_pend | ~rx_s;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: default 8E1 receiver plus two 7-bit, 2-stop variants (odd parity / no parity).
// Frames are bit-banged on separate rx lines; a negedge monitor records rx_valid cycles per instance.
module tb_uart_rx_cfg;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_line [3];

  logic [7:0] d0;
  logic [6:0] d1, d2;
  logic       v0, pe0, fe0, b0;
  logic       v1, pe1, fe1, b1;
  logic       v2, pe2, fe2, b2;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int t0    = 0;
  int npulse     [3] = '{0, 0, 0};
  int last_pulse [3] = '{0, 0, 0};
  int prev_pulse [3] = '{0, 0, 0};
  int base_n;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_cfg u_dut (
    .clk(clk), .rst(rst), .rx(rx_line[0]), .data_out(d0), .rx_valid(v0),
    .parity_err(pe0), .frame_err(fe0), .busy(b0)
  );

  uart_rx_cfg #(.DATA_BITS(7), .PARITY_ODD(1'b1), .STOP_BITS(2)) u_dut7 (
    .clk(clk), .rst(rst), .rx(rx_line[1]), .data_out(d1), .rx_valid(v1),
    .parity_err(pe1), .frame_err(fe1), .busy(b1)
  );

  uart_rx_cfg #(.DATA_BITS(7), .PARITY_EN(1'b0), .PARITY_ODD(1'b1), .STOP_BITS(2)) u_dut7n (
    .clk(clk), .rst(rst), .rx(rx_line[2]), .data_out(d2), .rx_valid(v2),
    .parity_err(pe2), .frame_err(fe2), .busy(b2)
  );

  // Every cycle rx_valid is high counts as one pulse, so a stretched pulse shows up as an extra count.
  always @(negedge clk) begin
    logic [2:0] vld;
    vld = {v2, v1, v0};
    for (int i = 0; i < 3; i++) begin
      if (vld[i]) begin
        npulse[i]++;
        prev_pulse[i] = last_pulse[i];
        last_pulse[i] = cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame LSB first; parity is computed here and optionally inverted.
  task automatic send(input int line, input logic [8:0] d, input int nbits, input bit pen,
                      input bit odd, input bit flip, input int nstop, input bit stop0);
    logic p;
    p  = odd;
    t0 = cyc;
    rx_line[line] = 1'b0;
    tick(CPB);
    for (int i = 0; i < nbits; i++) begin
      rx_line[line] = d[i];
      p ^= d[i];
      tick(CPB);
    end
    if (pen) begin
      rx_line[line] = p ^ flip;
      tick(CPB);
    end
    for (int i = 0; i < nstop; i++) begin
      rx_line[line] = !(stop0 && i == 0);
      tick(CPB);
    end
    rx_line[line] = 1'b1;
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rx_line[0] = 1'b1;
    rx_line[1] = 1'b1;
    rx_line[2] = 1'b1;
    rst = 1'b1;
    tick(5);
    rst = 1'b0;
    tick(2);
    chk("rst_data", 32'(d0), 32'h0);
    chk("rst_valid", 32'(v0), 32'h0);
    chk("rst_perr", 32'(pe0), 32'h0);
    chk("rst_ferr", 32'(fe0), 32'h0);
    chk("rst_busy", 32'(b0), 32'h0);

    // Clean 0xA5, even parity bit 0: pulse 171 cycles after rx falls (edge 170).
    send(0, 9'h0A5, 8, 1'b1, 1'b0, 1'b0, 1, 1'b0);
    chk("a5_npulse", 32'(npulse[0]), 32'd1);
    chk("a5_latency", 32'(last_pulse[0] - t0), 32'd171);
    chk("a5_data", 32'(d0), 32'hA5);
    chk("a5_perr", 32'(pe0), 32'h0);
    chk("a5_ferr", 32'(fe0), 32'h0);
    chk("a5_busy", 32'(b0), 32'h0);

    // Same word with parity bit 1.
    send(0, 9'h0A5, 8, 1'b1, 1'b0, 1'b1, 1, 1'b0);
    chk("perr_npulse", 32'(npulse[0]), 32'd2);
    chk("perr_data", 32'(d0), 32'hA5);
    chk("perr_perr", 32'(pe0), 32'h1);
    chk("perr_ferr", 32'(fe0), 32'h0);

    // Stop bit low, then a clean 0x3C after a short idle.
    send(0, 9'h05A, 8, 1'b1, 1'b0, 1'b0, 1, 1'b1);
    chk("ferr_npulse", 32'(npulse[0]), 32'd3);
    chk("ferr_data", 32'(d0), 32'h5A);
    chk("ferr_ferr", 32'(fe0), 32'h1);
    chk("ferr_perr", 32'(pe0), 32'h0);
    tick(2 * CPB);
    chk("ferr_idle_busy", 32'(b0), 32'h0);
    chk("ferr_idle_npulse", 32'(npulse[0]), 32'd3);
    send(0, 9'h03C, 8, 1'b1, 1'b0, 1'b0, 1, 1'b0);
    chk("c3_npulse", 32'(npulse[0]), 32'd4);
    chk("c3_data", 32'(d0), 32'h3C);
    chk("c3_ferr", 32'(fe0), 32'h0);

    // 4-cycle glitch: start detected, then rejected at mid-start.
    tick(CPB);
    rx_line[0] = 1'b0;
    tick(4);
    rx_line[0] = 1'b1;
    chk("glitch_busy_hi", 32'(b0), 32'h1);
    tick(3 * CPB);
    chk("glitch_busy_lo", 32'(b0), 32'h0);
    chk("glitch_npulse", 32'(npulse[0]), 32'd4);
    chk("glitch_data", 32'(d0), 32'h3C);
    chk("glitch_ferr", 32'(fe0), 32'h0);

    // Reset in the middle of the data bits of 0xFF.
    rx_line[0] = 1'b0;
    tick(CPB);
    rx_line[0] = 1'b1;
    tick(3 * CPB);
    chk("abort_busy_hi", 32'(b0), 32'h1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(12 * CPB);
    chk("abort_npulse", 32'(npulse[0]), 32'd4);
    chk("abort_data", 32'(d0), 32'h0);
    chk("abort_busy_lo", 32'(b0), 32'h0);
    send(0, 9'h012, 8, 1'b1, 1'b0, 1'b0, 1, 1'b0);
    chk("post_abort_npulse", 32'(npulse[0]), 32'd5);
    chk("post_abort_data", 32'(d0), 32'h12);
    chk("post_abort_perr", 32'(pe0), 32'h0);

    // 7-bit, odd parity, 2 stop: back-to-back frames, 11 bits each.
    base_n = npulse[1];
    send(1, 9'h055, 7, 1'b1, 1'b1, 1'b0, 2, 1'b0);
    chk("p7_first_data", 32'(d1), 32'h55);
    chk("p7_first_perr", 32'(pe1), 32'h0);
    send(1, 9'h02A, 7, 1'b1, 1'b1, 1'b0, 2, 1'b0);
    chk("p7_npulse", 32'(npulse[1] - base_n), 32'd2);
    chk("p7_spacing", 32'(last_pulse[1] - prev_pulse[1]), 32'd176);
    chk("p7_data", 32'(d1), 32'h2A);
    chk("p7_perr", 32'(pe1), 32'h0);
    chk("p7_ferr", 32'(fe1), 32'h0);

    // 7-bit, no parity, 2 stop: back-to-back frames, 10 bits each.
    base_n = npulse[2];
    send(2, 9'h055, 7, 1'b0, 1'b1, 1'b0, 2, 1'b0);
    chk("n7_first_data", 32'(d2), 32'h55);
    send(2, 9'h02A, 7, 1'b0, 1'b1, 1'b0, 2, 1'b0);
    chk("n7_npulse", 32'(npulse[2] - base_n), 32'd2);
    chk("n7_spacing", 32'(last_pulse[2] - prev_pulse[2]), 32'd160);
    chk("n7_data", 32'(d2), 32'h2A);
    chk("n7_perr", 32'(pe2), 32'h0);
    chk("n7_ferr", 32'(fe2), 32'h0);
    tick(CPB);
    chk("n7_busy", 32'(b2), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
